// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with a small line parser for an HC-05 link.
// The parser accepts "V1", "V0", "VA" to set the ventilator mode, and
// "Tdd" / "Hdd" to set the temperature or humidity upper threshold.
// Each command line ends with LF. CR characters are ignored.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT  = 5208,
    parameter int TEMP_MAX_INIT = 24,
    parameter int HUM_MAX_INIT  = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [1:0]  vent_mode,
    output logic [15:0] temp_max,
    output logic [15:0] hum_max,
    output logic        cmd_ok,
    output logic        cmd_err
);

    // The bit-period counter only has to reach CLKS_PER_BIT-1.
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_V  = 8'h56;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_A  = 8'h41;

    localparam logic [1:0] VENT_AUTO = 2'b00;
    localparam logic [1:0] VENT_ON   = 2'b01;
    localparam logic [1:0] VENT_OFF  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic          rx_meta_q;
    logic          rx_sync_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          stop_hold_q;   // stop bit was low; waiting for the line to return high
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          frame_err_q;

    // ------------------------------------------------------------------
    // Parser state
    // ------------------------------------------------------------------
    logic [7:0]  line_q [0:2];
    logic [1:0]  len_q;
    logic [1:0]  len_d;
    logic        ovf_q;
    logic        ovf_d;
    logic [1:0]  vent_q;
    logic [1:0]  vent_d;
    logic [15:0] temp_q;
    logic [15:0] temp_d;
    logic [15:0] hum_q;
    logic [15:0] hum_d;
    logic        cmd_ok_q;
    logic        cmd_ok_d;
    logic        cmd_err_q;
    logic        cmd_err_d;
    logic        line_wr;
    logic        line_clr;

    // Line decode results
    logic        is_vent_cmd;
    logic [1:0]  vent_val;
    logic        is_temp_cmd;
    logic        is_hum_cmd;
    logic [6:0]  field_val;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= 8'h39);
    endfunction

    // Two-flop synchronizer on the asynchronous serial input; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver FSM: find the start bit centre, then sample each bit one period apart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            stop_hold_q <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q       <= '0;
                    bit_idx_q   <= '0;
                    stop_hold_q <= 1'b0;
                    if (!rx_sync_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        // A line that is high again at mid start bit was only a glitch.
                        state_q <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (stop_hold_q) begin
                        if (rx_sync_q) begin
                            stop_hold_q <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end else if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            stop_hold_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Decode the buffered line into a candidate command.
    always_comb begin
        is_vent_cmd = 1'b0;
        vent_val    = VENT_AUTO;
        is_temp_cmd = 1'b0;
        is_hum_cmd  = 1'b0;
        field_val   = 7'(line_q[1][3:0]) * 7'd10 + 7'(line_q[2][3:0]);
        if (!ovf_q && len_q == 2'd2 && line_q[0] == CH_V) begin
            if (line_q[1] == CH_1) begin
                is_vent_cmd = 1'b1;
                vent_val    = VENT_ON;
            end else if (line_q[1] == CH_0) begin
                is_vent_cmd = 1'b1;
                vent_val    = VENT_OFF;
            end else if (line_q[1] == CH_A) begin
                is_vent_cmd = 1'b1;
                vent_val    = VENT_AUTO;
            end
        end
        if (!ovf_q && len_q == 2'd3 && is_digit(line_q[1]) && is_digit(line_q[2])) begin
            is_temp_cmd = (line_q[0] == CH_T);
            is_hum_cmd  = (line_q[0] == CH_H);
        end
    end

    // Parser next state: append bytes, evaluate on LF, flush on framing errors.
    always_comb begin
        len_d     = len_q;
        ovf_d     = ovf_q;
        vent_d    = vent_q;
        temp_d    = temp_q;
        hum_d     = hum_q;
        cmd_ok_d  = 1'b0;
        cmd_err_d = 1'b0;
        line_wr   = 1'b0;
        line_clr  = 1'b0;
        if (frame_err_q) begin
            len_d    = 2'd0;
            ovf_d    = 1'b0;
            line_clr = 1'b1;
        end else if (rx_valid_q) begin
            if (rx_byte_q == CH_LF) begin
                len_d = 2'd0;
                ovf_d = 1'b0;
                if (is_vent_cmd) begin
                    vent_d   = vent_val;
                    cmd_ok_d = 1'b1;
                end else if (is_temp_cmd) begin
                    temp_d   = {9'd0, field_val};
                    cmd_ok_d = 1'b1;
                end else if (is_hum_cmd) begin
                    hum_d    = {9'd0, field_val};
                    cmd_ok_d = 1'b1;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else if (rx_byte_q != CH_CR) begin
                if (len_q == 2'd3) begin
                    ovf_d = 1'b1;
                end else begin
                    line_wr = 1'b1;
                    len_d   = len_q + 2'd1;
                end
            end
        end
    end

    // Line buffer: the byte goes into the slot indexed by the current length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                line_q[i] <= 8'h00;
            end
        end else if (line_clr) begin
            for (int i = 0; i < 3; i++) begin
                line_q[i] <= 8'h00;
            end
        end else if (line_wr) begin
            line_q[len_q] <= rx_byte_q;
        end
    end

    // Parser registers and settings; settings only move on an accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= 2'd0;
            ovf_q     <= 1'b0;
            vent_q    <= VENT_AUTO;
            temp_q    <= 16'(TEMP_MAX_INIT);
            hum_q     <= 16'(HUM_MAX_INIT);
            cmd_ok_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            vent_q    <= vent_d;
            temp_q    <= temp_d;
            hum_q     <= hum_d;
            cmd_ok_q  <= cmd_ok_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign vent_mode = vent_q;
    assign temp_max  = temp_q;
    assign hum_max   = hum_q;
    assign cmd_ok    = cmd_ok_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed stimulus for uart_cmd_rx with a scoreboard.
// Each received byte or framing error and each command-line outcome is
// queued when it is sent. A negedge monitor pops the queue and checks it.
// A short bit period keeps run time small. The glitch is scaled to the same
// fraction of a bit that 1000 clocks is at 9600 baud.
module tb_uart_cmd_rx;

    localparam int CPB         = 64;
    localparam int GLITCH_CLKS = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;
    logic [1:0]  vent_mode;
    logic [15:0] temp_max;
    logic [15:0] hum_max;
    logic        cmd_ok;
    logic        cmd_err;

    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .TEMP_MAX_INIT(24),
        .HUM_MAX_INIT (80)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .vent_mode(vent_mode),
        .temp_max (temp_max),
        .hum_max  (hum_max),
        .cmd_ok   (cmd_ok),
        .cmd_err  (cmd_err)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       fe;
        logic [7:0] b;
    } rx_ev_t;

    typedef struct packed {
        logic        ok;
        logic [1:0]  vent;
        logic [15:0] temp;
        logic [15:0] hum;
    } cmd_ev_t;

    rx_ev_t  rx_exp[$];
    cmd_ev_t cmd_exp[$];
    rx_ev_t  mon_rx;
    cmd_ev_t mon_cmd;

    // Settings the bench expects the DUT to hold right now
    logic [1:0]  m_vent = 2'b00;
    logic [15:0] m_temp = 16'd24;
    logic [15:0] m_hum  = 16'd80;
    logic        nl_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic ok);
        cmd_ev_t c;
        c.ok   = ok;
        c.vent = m_vent;
        c.temp = m_temp;
        c.hum  = m_hum;
        cmd_exp.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx_ev_t e;
        e.fe = !stop_ok;
        e.b  = b;
        rx_exp.push_back(e);
        $display("tx byte %02h stop_ok=%0d", b, stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (2 * CPB) @(negedge clk);
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_line(input string s);
        logic [7:0] ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            send_byte(ch, 1'b1);
        end
        send_byte(8'h0A, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_byte"},   rx_byte,   8'h00);
        check({tag, "_rx_valid"},  rx_valid,  1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_cmd_ok"},    cmd_ok,    1'b0);
        check({tag, "_cmd_err"},   cmd_err,   1'b0);
        check({tag, "_vent"},      vent_mode, 2'b00);
        check({tag, "_temp"},      temp_max,  16'd24);
        check({tag, "_hum"},       hum_max,   16'd80);
    endtask

    // Monitor: compare every DUT event against the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            nl_prev = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                if (rx_exp.size() == 0) begin
                    check("rx_unexpected", {rx_valid, frame_err, rx_byte}, 10'd0);
                end else begin
                    mon_rx = rx_exp.pop_front();
                    check("rx_frame_err", frame_err, mon_rx.fe);
                    check("rx_valid", rx_valid, !mon_rx.fe);
                    if (!mon_rx.fe) begin
                        check("rx_byte", rx_byte, mon_rx.b);
                        $display("rx byte %02h", rx_byte);
                    end else begin
                        $display("rx frame error");
                    end
                end
            end
            if (nl_prev) begin
                if (cmd_exp.size() == 0) begin
                    check("cmd_unexpected", {cmd_ok, cmd_err}, 2'b00);
                end else begin
                    mon_cmd = cmd_exp.pop_front();
                    check("cmd_ok",   cmd_ok,    mon_cmd.ok);
                    check("cmd_err",  cmd_err,   !mon_cmd.ok);
                    check("vent",     vent_mode, mon_cmd.vent);
                    check("temp_max", temp_max,  mon_cmd.temp);
                    check("hum_max",  hum_max,   mon_cmd.hum);
                    $display("cmd ok=%0d err=%0d vent=%0b temp=%0d hum=%0d",
                             cmd_ok, cmd_err, vent_mode, temp_max, hum_max);
                end
            end else if (cmd_ok || cmd_err) begin
                check("cmd_stray", {cmd_ok, cmd_err}, 2'b00);
            end
            nl_prev = rx_valid && (rx_byte == 8'h0A);
        end
    end

    initial begin
        logic [7:0] t_ch;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte. It leaves "U" in the line buffer, so the bare LF after it is rejected.
        send_byte(8'h55, 1'b1);
        push_cmd(1'b0);
        send_line("");

        // Mode commands; CR inside the line is ignored
        m_vent = 2'b01;
        push_cmd(1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        m_vent = 2'b00;
        push_cmd(1'b1);
        send_line("VA");

        // Thresholds
        m_temp = 16'd30;
        push_cmd(1'b1);
        send_line("T30");
        m_hum = 16'd65;
        push_cmd(1'b1);
        send_line("H65");

        // Rejected lines: non-digit, overflow, empty
        push_cmd(1'b0);
        send_line("T3X");
        push_cmd(1'b0);
        send_line("V1234");
        push_cmd(1'b0);
        send_line("");
        check("settings_after_errors", {vent_mode, temp_max, hum_max}, {m_vent, m_temp, m_hum});

        // Framing error, then a good line
        send_byte(8'h41, 1'b0);
        m_vent = 2'b10;
        push_cmd(1'b1);
        send_line("V0");

        // Short low glitch: the monitor flags any event it produces
        $display("glitch %0d clocks", GLITCH_CLKS);
        rx = 1'b0;
        repeat (GLITCH_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("rx_byte_after_glitch", rx_byte, 8'h0A);
        check("vent_after_glitch", vent_mode, 2'b10);

        // Reset in the middle of the data bits of "T"
        $display("reset during DATA of T");
        t_ch = 8'h54;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = t_ch[i];
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("midframe_reset");
        m_vent = 2'b00;
        m_temp = 16'd24;
        m_hum  = 16'd80;
        reset = 1'b0;
        repeat (CPB) @(negedge clk);
        m_hum = 16'd70;
        push_cmd(1'b1);
        send_line("H70");

        repeat (2 * CPB) @(negedge clk);
        check("final_settings", {vent_mode, temp_max, hum_max}, {m_vent, m_temp, m_hum});
        check("rx_events_missing", rx_exp.size(), 0);
        check("cmd_events_missing", cmd_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 The module SHALL have one clock, `clk` (50 MHz); reset is asynchronous and active-high, named `reset`.
REQ-002 Parameter `CLKS_PER_BIT`, default 5208, SHALL set the clocks per bit (9600 baud at 50 MHz).
REQ-003 Parameter `TEMP_MAX_INIT`, default 24, SHALL set the reset value of `temp_max`.
REQ-004 Parameter `HUM_MAX_INIT`, default 80, SHALL set the reset value of `hum_max`.
REQ-005 Port list SHALL be, one per line:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous active-high reset.
- `rx` input 1: serial line from the HC-05 TXD; idles high.
- `rx_byte` output 8: last correctly framed byte.
- `rx_valid` output 1: one-cycle pulse when `rx_byte` updates.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `vent_mode` output 2: ventilator mode. 00 = auto, 01 = forced on, 10 = forced off.
- `temp_max` output 16: temperature upper threshold.
- `hum_max` output 16: humidity upper threshold.
- `cmd_ok` output 1: one-cycle pulse when a command is accepted.
- `cmd_err` output 1: one-cycle pulse when a command line is rejected.

Function
REQ-006 `rx` SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-007 The receiver FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-008 IDLE: a low synchronized `rx` SHALL move the FSM to START with the bit counter cleared.
REQ-009 START: at count `CLKS_PER_BIT/2-1`:
- if `rx` is low, the FSM SHALL go to DATA with the counter cleared;
- if `rx` is high, the FSM SHALL return to IDLE (glitch rejected, no pulse).
REQ-010 DATA: every `CLKS_PER_BIT` clocks the FSM SHALL sample one bit, LSB first, and go to STOP after bit 7.
REQ-011 STOP: after `CLKS_PER_BIT` clocks, the FSM SHALL sample the stop bit.
- High: load `rx_byte` and pulse `rx_valid`, then go to IDLE.
- Low: pulse `frame_err`, discard the byte, and stay in STOP until `rx` is high, then go to IDLE.
REQ-012 The parser SHALL hold a 3-byte line buffer and a length counter of 0..3, plus an overflow flag.
REQ-013 Each valid byte other than 0x0A or 0x0D SHALL be appended to the line buffer.
- When the length is already 3, the byte is not stored and the overflow flag is set.
REQ-014 Byte 0x0D SHALL be ignored.
REQ-015 Byte 0x0A SHALL evaluate the line, then clear the length and overflow flag.
REQ-016 A line of length 2 SHALL be accepted as follows:
- "V1" sets `vent_mode`=01;
- "V0" sets `vent_mode`=10;
- "VA" sets `vent_mode`=00.
REQ-017 A line of length 3 of the form "T" or "H" followed by two ASCII digits d1 d2 SHALL be accepted:
- the field value is d1*10+d2, zero-extended to 16 bits;
- "T" writes `temp_max`, "H" writes `hum_max`.
REQ-018 Any other line SHALL pulse `cmd_err` and leave all settings unchanged. This includes an empty line, an overflowed line, lowercase letters and non-digit characters.
REQ-019 Setting updates and the `cmd_ok` or `cmd_err` pulse SHALL occur on the clock edge following the `rx_valid` cycle carrying 0x0A (1-cycle latency).
REQ-020 A `frame_err` SHALL clear the line buffer, length and overflow flag; no `cmd_err` is generated.
REQ-021 `cmd_ok` and `cmd_err` SHALL never be asserted in the same cycle.
REQ-022 Settings SHALL hold their value indefinitely until the next accepted command.

Reset
REQ-023 While `reset` is high, the FSM SHALL be in IDLE, with all counters and the line buffer cleared and the synchronizer flops set to 1.
REQ-024 Reset output values SHALL be:
- `rx_byte`=0, `rx_valid`=0, `frame_err`=0, `cmd_ok`=0, `cmd_err`=0;
- `vent_mode`=00;
- `temp_max`=`TEMP_MAX_INIT`, `hum_max`=`HUM_MAX_INIT`.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes at the next falling edge after release.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Byte: send 0x55 at 9600 baud with a valid stop bit -> exactly one `rx_valid` pulse, `rx_byte`=0x55.
- Mode: send "V1\r\n" -> `vent_mode`=01 and one `cmd_ok` pulse, one cycle after the 0x0A `rx_valid`; then "VA\n" -> `vent_mode`=00.
- Threshold: send "T30\n" then "H65\n" -> `temp_max`=30, `hum_max`=65, two `cmd_ok` pulses.
- Errors: send "T3X\n", "V1234\n" and "\n" -> three `cmd_err` pulses and no change to settings.
- Framing: send 0x41 with stop bit low and `rx` held low for 2 bit times, then "V0\n" -> one `frame_err`, then `vent_mode`=10.
- Glitch and reset: a 1000-clock low pulse on `rx` -> no `rx_valid` or `frame_err`; `reset` asserted during DATA of "T" -> outputs at reset values, the next "H70\n" gives `hum_max`=70.
